xain_gfx_rom_reader: RTL and testbench

Read side of the ROM region map. It serves the three graphics fetch clients (BACK1, BACK2, OBJ) from SDRAM. Each client offset is translated to a byte address using the shared region table: base address plus 16-bit byte reorder. The block arbitrates the clients round-robin onto a single SDRAM read port and returns 32-bit words. It sits between the tile/sprite generators and the SDRAM controller, mirroring the loader that wrote those regions.

---
 rtl/xain_gfx_rom_reader_pkg.sv | 42 ++++
 rtl/xain_gfx_rom_reader_if.sv | 29 ++
 rtl/xain_rr_arbiter.sv | 38 +++
 rtl/xain_gfx_rom_reader.sv | 157 +++++++++++++++
 tb/tb_xain_gfx_rom_reader.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/xain_gfx_rom_reader_pkg.sv
// Shared ROM region map: region descriptors and the graphics read-side view of them.
package xain_gfx_rom_reader_pkg;

  localparam int GFX_DW = 32;   // SDRAM / client data width
  localparam int SDR_AW = 25;   // SDRAM byte address width

  typedef struct packed {
    logic [SDR_AW-1:0] base_addr;
    logic              reorder_16;
  } region_t;

  // Graphics regions written by the ROM loader (256 KB each).
  localparam region_t REGION_BACK1 = '{base_addr: 25'h004_0000, reorder_16: 1'b0};
  localparam region_t REGION_BACK2 = '{base_addr: 25'h008_0000, reorder_16: 1'b0};
  localparam region_t REGION_OBJ   = '{base_addr: 25'h00C_0000, reorder_16: 1'b0};

  localparam int GFX_CLIENT_BACK1 = 0;
  localparam int GFX_CLIENT_BACK2 = 1;
  localparam int GFX_CLIENT_OBJ   = 2;
  localparam int GFX_NUM_CLIENTS  = 3;

  typedef enum logic [1:0] {
    GFX_CL_BACK1 = 2'd0,
    GFX_CL_BACK2 = 2'd1,
    GFX_CL_OBJ   = 2'd2
  } gfx_client_t;

  // Indexed by client number.
  localparam region_t GFX_REGIONS [GFX_NUM_CLIENTS] = '{REGION_BACK1, REGION_BACK2, REGION_OBJ};

  // Word offset to byte address; overflow past 25 bits wraps silently.
  function automatic logic [SDR_AW-1:0] gfx_byte_addr(input logic [SDR_AW-1:0] base,
                                                      input logic [15:0] off);
    return base + {7'b0, off, 2'b00};
  endfunction

  // Swap bytes inside each 16-bit half.
  function automatic logic [GFX_DW-1:0] gfx_reorder16(input logic [GFX_DW-1:0] d);
    return {d[23:16], d[31:24], d[7:0], d[15:8]};
  endfunction

endpackage

// File: rtl/xain_gfx_rom_reader_if.sv
// Client fetch + SDRAM read port bundle for the graphics ROM reader.
interface xain_gfx_rom_reader_if
  import xain_gfx_rom_reader_pkg::*;
#(
  parameter int NCLIENT = 3,
  parameter int OFFW    = 16
);
  logic                          rom_load_busy;
  logic [NCLIENT-1:0]            cl_req;
  logic [NCLIENT-1:0][OFFW-1:0]  cl_off;
  logic [GFX_DW-1:0]             cl_data;
  logic [NCLIENT-1:0]            cl_valid;
  logic [SDR_AW-1:0]             sdr_addr;
  logic                          sdr_req;
  logic                          sdr_rdy;
  logic [GFX_DW-1:0]             sdr_data;

  // Environment side: clients, loader status and SDRAM controller.
  modport master (
    output rom_load_busy, cl_req, cl_off, sdr_rdy, sdr_data,
    input  cl_data, cl_valid, sdr_addr, sdr_req
  );

  // Reader block side.
  modport slave (
    input  rom_load_busy, cl_req, cl_off, sdr_rdy, sdr_data,
    output cl_data, cl_valid, sdr_addr, sdr_req
  );
endinterface

// File: rtl/xain_rr_arbiter.sv
// Round-robin grant; search starts at the client after the last grant.
module xain_rr_arbiter #(
  parameter int N = 3,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [N-1:0] req_i,
  input  logic         take_i,
  output logic         gnt_vld_o,
  output logic [W-1:0] gnt_idx_o
);
  logic [W-1:0] ptr_q, ptr_d;

  // Pick the first requester at or after the pointer, scanning downward so the nearest wins.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % N;
      if (req_i[idx]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = W'(idx);
      end
    end
    ptr_d = ptr_q;
    if (take_i && gnt_vld_o)
      ptr_d = (gnt_idx_o == W'(N - 1)) ? '0 : gnt_idx_o + W'(1);
  end

  // Pointer moves only when a grant is taken.
  always_ff @(posedge clk_i) begin
    if (reset_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
endmodule

// File: rtl/xain_gfx_rom_reader.sv
// Graphics ROM read side: per-client pending + one-entry cache, round-robin onto one SDRAM read port.
module xain_gfx_rom_reader
  import xain_gfx_rom_reader_pkg::*;
#(
  parameter int                 NCLIENT       = 3,
  parameter int                 OFFW          = 16,
  parameter logic [NCLIENT-1:0] REORDER_FORCE = '0  // extra per-client reorder enable, ORed with the region bit
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  xain_gfx_rom_reader_if.slave   bus
);
  localparam int GW = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RET   = 2'd3;

  logic [1:0]                   state_q, state_d;
  logic [GW-1:0]                gnt_q, gnt_d;
  logic [NCLIENT-1:0]           pend_q, pend_d;
  logic [NCLIENT-1:0][OFFW-1:0] off_q, off_d;
  logic [NCLIENT-1:0]           cvld_q, cvld_d;
  logic [NCLIENT-1:0][OFFW-1:0] coff_q, coff_d;
  logic [NCLIENT-1:0][31:0]     cdat_q, cdat_d;
  logic [NCLIENT-1:0]           ret_q, ret_d;
  logic                         load_q;
  logic                         sdr_req_q, sdr_req_d;
  logic [SDR_AW-1:0]            sdr_addr_q, sdr_addr_d;
  logic [NCLIENT-1:0]           cl_valid_q, cl_valid_d;
  logic [31:0]                  cl_data_q, cl_data_d;

  logic                         load_rise;
  logic [31:0]                  rd_word;
  logic [NCLIENT-1:0]           busy, hit, mret, rreq;
  logic                         arb_vld, arb_take;
  logic [GW-1:0]                arb_idx;

  xain_rr_arbiter #(.N(NCLIENT), .W(GW)) u_arb (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_i     (pend_q),
    .take_i    (arb_take),
    .gnt_vld_o (arb_vld),
    .gnt_idx_o (arb_idx)
  );

  // Client side: hit detect, miss capture, cache fill on SDRAM return, flush on loader start.
  always_comb begin
    load_rise = bus.rom_load_busy & ~load_q;
    rd_word   = (GFX_REGIONS[gnt_q].reorder_16 | REORDER_FORCE[gnt_q])
              ? gfx_reorder16(bus.sdr_data) : bus.sdr_data;
    busy      = pend_q | ret_q;
    pend_d    = pend_q;
    off_d     = off_q;
    cvld_d    = load_rise ? '0 : cvld_q;
    coff_d    = coff_q;
    cdat_d    = cdat_q;
    for (int i = 0; i < NCLIENT; i++) begin
      mret[i] = (state_q == S_WAIT) && bus.sdr_rdy && (gnt_q == GW'(i));
      hit[i]  = bus.cl_req[i] && !busy[i] && cvld_q[i] && !load_rise
                && (coff_q[i] == bus.cl_off[i]);
      if (bus.cl_req[i] && !busy[i] && !hit[i]) begin
        pend_d[i] = 1'b1;
        off_d[i]  = bus.cl_off[i];
      end
      // An in-flight read refills its cache even across a loader flush.
      if (mret[i]) begin
        pend_d[i] = 1'b0;
        cvld_d[i] = 1'b1;
        coff_d[i] = off_q[i];
        cdat_d[i] = rd_word;
      end
    end
  end

  // Return path: one client per cycle on the shared data bus, lowest index first.
  always_comb begin
    logic found;
    found      = 1'b0;
    rreq       = ret_q | hit | mret;
    cl_valid_d = '0;
    cl_data_d  = cl_data_q;
    for (int i = 0; i < NCLIENT; i++) begin
      if (rreq[i] && !found) begin
        found         = 1'b1;
        cl_valid_d[i] = 1'b1;
        cl_data_d     = mret[i] ? rd_word : cdat_q[i];
      end
    end
    ret_d = rreq & ~cl_valid_d;
  end

  // SDRAM FSM; the strobe is registered on the grant so it is high during ISSUE.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sdr_req_d  = 1'b0;
    sdr_addr_d = sdr_addr_q;
    arb_take   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!bus.rom_load_busy && arb_vld) begin
          arb_take   = 1'b1;
          gnt_d      = arb_idx;
          sdr_req_d  = 1'b1;
          sdr_addr_d = gfx_byte_addr(GFX_REGIONS[arb_idx].base_addr, off_q[arb_idx]);
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (bus.sdr_rdy) state_d = S_RET;
      S_RET:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops pendings, cache and any read in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      pend_q     <= '0;
      off_q      <= '0;
      cvld_q     <= '0;
      coff_q     <= '0;
      cdat_q     <= '0;
      ret_q      <= '0;
      load_q     <= 1'b0;
      sdr_req_q  <= 1'b0;
      sdr_addr_q <= '0;
      cl_valid_q <= '0;
      cl_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      pend_q     <= pend_d;
      off_q      <= off_d;
      cvld_q     <= cvld_d;
      coff_q     <= coff_d;
      cdat_q     <= cdat_d;
      ret_q      <= ret_d;
      load_q     <= bus.rom_load_busy;
      sdr_req_q  <= sdr_req_d;
      sdr_addr_q <= sdr_addr_d;
      cl_valid_q <= cl_valid_d;
      cl_data_q  <= cl_data_d;
    end
  end

  assign bus.sdr_req  = sdr_req_q;
  assign bus.sdr_addr = sdr_addr_q;
  assign bus.cl_valid = cl_valid_q;
  assign bus.cl_data  = cl_data_q;

endmodule

// File: tb/tb_xain_gfx_rom_reader.sv
// Directed bench for xain_gfx_rom_reader; OBJ has byte reorder forced on.
module tb_xain_gfx_rom_reader;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   req_cnt = 0;
  int   cv_cnt [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  xain_gfx_rom_reader_if #(.NCLIENT(3), .OFFW(16)) bus ();

  xain_gfx_rom_reader #(.NCLIENT(3), .OFFW(16), .REORDER_FORCE(3'b100)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  // Pulse counters for "nothing happened" checks.
  always @(posedge clk) begin
    if (bus.sdr_req) req_cnt <= req_cnt + 1;
    for (int i = 0; i < 3; i++)
      if (bus.cl_valid[i]) cv_cnt[i] <= cv_cnt[i] + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_req(input logic [2:0] m, input logic [15:0] o0, input logic [15:0] o1,
                           input logic [15:0] o2);
    bus.cl_req    = m;
    bus.cl_off[0] = o0;
    bus.cl_off[1] = o1;
    bus.cl_off[2] = o2;
    tick();
    bus.cl_req = '0;
  endtask

  // Cycles until sdr_req is seen (-1 on timeout) and the address it carried.
  task automatic wait_req(output int cyc, output logic [24:0] addr);
    cyc  = -1;
    addr = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.sdr_req) begin
        cyc  = k;
        addr = bus.sdr_addr;
        break;
      end
    end
  endtask

  task automatic rdy_pulse(input int dly, input logic [31:0] d);
    repeat (dly) tick();
    bus.sdr_rdy  = 1'b1;
    bus.sdr_data = d;
    tick();
    bus.sdr_rdy  = 1'b0;
    bus.sdr_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_cmp++; if (bus.sdr_req !== 1'b0) begin n_err++; $display("FAIL reset_sdr_req: got %b want 0", bus.sdr_req); end
    n_cmp++; if (bus.sdr_addr !== 25'h0) begin n_err++; $display("FAIL reset_sdr_addr: got %h want 0", bus.sdr_addr); end
    n_cmp++; if (bus.cl_valid !== 3'b000) begin n_err++; $display("FAIL reset_cl_valid: got %b want 000", bus.cl_valid); end
    n_cmp++; if (bus.cl_data !== 32'h0) begin n_err++; $display("FAIL reset_cl_data: got %h want 0", bus.cl_data); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_miss_hit();
    int cyc; logic [24:0] a; int rq0;
    pulse_req(3'b001, 16'h0001, 16'h0, 16'h0);
    wait_req(cyc, a);
    n_cmp++; if (cyc != 1) begin n_err++; $display("FAIL miss_latency: got %0d want 1", cyc); end
    n_cmp++; if (a !== 25'h004_0004) begin n_err++; $display("FAIL miss_addr: got %h want 0040004", a); end
    rdy_pulse(3, 32'h1122_3344);
    n_cmp++; if (bus.cl_valid !== 3'b001) begin n_err++; $display("FAIL miss_valid: got %b want 001", bus.cl_valid); end
    n_cmp++; if (bus.cl_data !== 32'h1122_3344) begin n_err++; $display("FAIL miss_data: got %h want 11223344", bus.cl_data); end
    rq0 = req_cnt;
    pulse_req(3'b001, 16'h0001, 16'h0, 16'h0);
    n_cmp++; if (bus.cl_valid !== 3'b001) begin n_err++; $display("FAIL hit_valid: got %b want 001", bus.cl_valid); end
    n_cmp++; if (bus.cl_data !== 32'h1122_3344) begin n_err++; $display("FAIL hit_data: got %h want 11223344", bus.cl_data); end
    tick(); tick(); tick();
    n_cmp++; if (req_cnt != rq0) begin n_err++; $display("FAIL hit_no_sdr: got %0d reqs want 0", req_cnt - rq0); end
  endtask

  task automatic test_obj_reorder();
    int cyc; logic [24:0] a;
    pulse_req(3'b100, 16'h0, 16'h0, 16'hFFFF);
    wait_req(cyc, a);
    n_cmp++; if (cyc != 1) begin n_err++; $display("FAIL obj_latency: got %0d want 1", cyc); end
    n_cmp++; if (a !== 25'h00F_FFFC) begin n_err++; $display("FAIL obj_addr: got %h want 00FFFFC", a); end
    rdy_pulse(2, 32'hAABB_CCDD);
    n_cmp++; if (bus.cl_valid !== 3'b100) begin n_err++; $display("FAIL obj_valid: got %b want 100", bus.cl_valid); end
    n_cmp++; if (bus.cl_data !== 32'hBBAA_DDCC) begin n_err++; $display("FAIL obj_reorder: got %h want BBAADDCC", bus.cl_data); end
  endtask

  task automatic test_back_to_back();
    int cyc; logic [24:0] a;
    pulse_req(3'b111, 16'h0010, 16'h0020, 16'h0030);
    wait_req(cyc, a);
    n_cmp++; if (a !== 25'h004_0040) begin n_err++; $display("FAIL rr_first: got %h want 0040040", a); end
    rdy_pulse(1, 32'hB100_0010);
    n_cmp++; if (bus.cl_valid !== 3'b001 || bus.cl_data !== 32'hB100_0010) begin n_err++; $display("FAIL rr_ret0: got %b/%h want 001/B1000010", bus.cl_valid, bus.cl_data); end
    wait_req(cyc, a);
    n_cmp++; if (cyc != 2) begin n_err++; $display("FAIL rr_gap: got %0d want 2 (4-cycle spacing)", cyc); end
    n_cmp++; if (a !== 25'h008_0080) begin n_err++; $display("FAIL rr_second: got %h want 0080080", a); end
    rdy_pulse(1, 32'hB200_0020);
    n_cmp++; if (bus.cl_valid !== 3'b010 || bus.cl_data !== 32'hB200_0020) begin n_err++; $display("FAIL rr_ret1: got %b/%h want 010/B2000020", bus.cl_valid, bus.cl_data); end
    wait_req(cyc, a);
    n_cmp++; if (a !== 25'h00C_00C0) begin n_err++; $display("FAIL rr_third: got %h want 00C00C0", a); end
    rdy_pulse(1, 32'h0B00_0030);
    n_cmp++; if (bus.cl_valid !== 3'b100 || bus.cl_data !== 32'h000B_3000) begin n_err++; $display("FAIL rr_ret2: got %b/%h want 100/000B3000", bus.cl_valid, bus.cl_data); end
    // Last grant was OBJ, so BACK2 wins next.
    pulse_req(3'b110, 16'h0, 16'h0021, 16'h0031);
    wait_req(cyc, a);
    n_cmp++; if (a !== 25'h008_0084) begin n_err++; $display("FAIL rr_b2_first: got %h want 0080084", a); end
    rdy_pulse(1, 32'hB200_0021);
    n_cmp++; if (bus.cl_valid !== 3'b010 || bus.cl_data !== 32'hB200_0021) begin n_err++; $display("FAIL rr_b2_ret: got %b/%h want 010/B2000021", bus.cl_valid, bus.cl_data); end
    wait_req(cyc, a);
    n_cmp++; if (a !== 25'h00C_00C4) begin n_err++; $display("FAIL rr_obj_next: got %h want 00C00C4", a); end
    rdy_pulse(1, 32'h1234_5678);
    n_cmp++; if (bus.cl_valid !== 3'b100 || bus.cl_data !== 32'h3412_7856) begin n_err++; $display("FAIL rr_obj_ret: got %b/%h want 100/34127856", bus.cl_valid, bus.cl_data); end
  endtask

  task automatic test_multi_hit();
    int rq0;
    rq0 = req_cnt;
    pulse_req(3'b111, 16'h0010, 16'h0021, 16'h0031);
    n_cmp++; if (bus.cl_valid !== 3'b001 || bus.cl_data !== 32'hB100_0010) begin n_err++; $display("FAIL mhit_0: got %b/%h want 001/B1000010", bus.cl_valid, bus.cl_data); end
    tick();
    n_cmp++; if (bus.cl_valid !== 3'b010 || bus.cl_data !== 32'hB200_0021) begin n_err++; $display("FAIL mhit_1: got %b/%h want 010/B2000021", bus.cl_valid, bus.cl_data); end
    tick();
    n_cmp++; if (bus.cl_valid !== 3'b100 || bus.cl_data !== 32'h3412_7856) begin n_err++; $display("FAIL mhit_2: got %b/%h want 100/34127856", bus.cl_valid, bus.cl_data); end
    tick();
    n_cmp++; if (bus.cl_valid !== 3'b000) begin n_err++; $display("FAIL mhit_done: got %b want 000", bus.cl_valid); end
    n_cmp++; if (req_cnt != rq0) begin n_err++; $display("FAIL mhit_no_sdr: got %0d reqs want 0", req_cnt - rq0); end
  endtask

  task automatic test_busy();
    int cyc; logic [24:0] a; int rq0; int c1;
    bus.rom_load_busy = 1'b1;
    tick();
    rq0 = req_cnt;
    c1  = cv_cnt[1];
    pulse_req(3'b010, 16'h0, 16'h0021, 16'h0);
    repeat (5) tick();
    n_cmp++; if (req_cnt != rq0) begin n_err++; $display("FAIL busy_no_sdr: got %0d reqs want 0", req_cnt - rq0); end
    n_cmp++; if (cv_cnt[1] != c1) begin n_err++; $display("FAIL busy_flushed: got %0d valids want 0", cv_cnt[1] - c1); end
    bus.rom_load_busy = 1'b0;
    wait_req(cyc, a);
    n_cmp++; if (cyc < 1 || cyc > 2) begin n_err++; $display("FAIL busy_release: got %0d want 1..2", cyc); end
    n_cmp++; if (a !== 25'h008_0084) begin n_err++; $display("FAIL busy_addr: got %h want 0080084", a); end
    rdy_pulse(1, 32'hB200_0121);
    n_cmp++; if (bus.cl_valid !== 3'b010 || bus.cl_data !== 32'hB200_0121) begin n_err++; $display("FAIL busy_ret: got %b/%h want 010/B2000121", bus.cl_valid, bus.cl_data); end
  endtask

  task automatic test_reset_mid();
    int cyc; logic [24:0] a; int rq0; int c0;
    pulse_req(3'b001, 16'h0005, 16'h0, 16'h0);
    wait_req(cyc, a);
    tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    rq0 = req_cnt;
    c0  = cv_cnt[0];
    bus.sdr_rdy  = 1'b1;
    bus.sdr_data = 32'hDEAD_BEEF;
    tick();
    bus.sdr_rdy  = 1'b0;
    bus.sdr_data = '0;
    repeat (4) tick();
    n_cmp++; if (cv_cnt[0] != c0) begin n_err++; $display("FAIL rst_late_rdy: got %0d valids want 0", cv_cnt[0] - c0); end
    n_cmp++; if (req_cnt != rq0) begin n_err++; $display("FAIL rst_no_reissue: got %0d reqs want 0", req_cnt - rq0); end
    pulse_req(3'b001, 16'h0005, 16'h0, 16'h0);
    wait_req(cyc, a);
    n_cmp++; if (cyc != 1) begin n_err++; $display("FAIL rst_fresh_lat: got %0d want 1", cyc); end
    n_cmp++; if (a !== 25'h004_0014) begin n_err++; $display("FAIL rst_fresh_addr: got %h want 0040014", a); end
    rdy_pulse(1, 32'h5555_AAAA);
    n_cmp++; if (bus.cl_valid !== 3'b001 || bus.cl_data !== 32'h5555_AAAA) begin n_err++; $display("FAIL rst_fresh_ret: got %b/%h want 001/5555AAAA", bus.cl_valid, bus.cl_data); end
  endtask

  task automatic test_ignore();
    int cyc; logic [24:0] a; int rq0; int c0;
    pulse_req(3'b001, 16'h0040, 16'h0, 16'h0);
    wait_req(cyc, a);
    n_cmp++; if (a !== 25'h004_0100) begin n_err++; $display("FAIL ign_addr: got %h want 0040100", a); end
    pulse_req(3'b001, 16'h0002, 16'h0, 16'h0);
    rq0 = req_cnt;
    c0  = cv_cnt[0];
    rdy_pulse(2, 32'hCAFE_F00D);
    n_cmp++; if (bus.cl_valid !== 3'b001 || bus.cl_data !== 32'hCAFE_F00D) begin n_err++; $display("FAIL ign_ret: got %b/%h want 001/CAFEF00D", bus.cl_valid, bus.cl_data); end
    repeat (6) tick();
    n_cmp++; if (cv_cnt[0] != c0 + 1) begin n_err++; $display("FAIL ign_one_valid: got %0d valids want 1", cv_cnt[0] - c0); end
    n_cmp++; if (req_cnt != rq0) begin n_err++; $display("FAIL ign_no_sdr: got %0d reqs want 0", req_cnt - rq0); end
  endtask

  initial begin
    reset             = 1'b1;
    bus.rom_load_busy = 1'b0;
    bus.cl_req        = '0;
    bus.cl_off        = '0;
    bus.sdr_rdy       = 1'b0;
    bus.sdr_data      = '0;
    test_reset();
    test_miss_hit();
    test_obj_reorder();
    test_back_to_back();
    test_multi_hit();
    test_busy();
    test_reset_mid();
    test_ignore();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
